// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM states,
// load/store size encodings and the access legality rule.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // An access is legal when its size is naturally aligned and the encoding
  // exists for its direction (unsigned sizes only make sense for loads).
  function automatic logic lsu_access_ok(input logic [2:0] f3,
                                         input logic [1:0] off,
                                         input logic       is_store);
    logic ok;
    case (f3)
      F3_LB:   ok = 1'b1;
      F3_LH:   ok = ~off[0];
      F3_LW:   ok = (off == 2'b00);
      F3_LBU:  ok = ~is_store;
      F3_LHU:  ok = ~is_store & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Load data extraction: picks the byte/half at the byte offset of a read word
// and sign- or zero-extends it. Purely combinational so forwarding paths can
// reuse it.
module lsu_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] sh_b;
  logic [31:0] sh_h;
  logic [7:0]  b;
  logic [15:0] h;

  // Align the selected lane to bit 0, then extend according to funct3.
  // NOTE: every signal written here gets a value on every path (defaults
  // first, default case arm), otherwise synthesis infers a latch.
  always_comb begin
    sh_b = rdata >> {off, 3'b000};
    sh_h = rdata >> {off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    data = 32'd0;
    case (funct3)
      F3_LB:   data = {{24{b[7]}}, b};
      F3_LH:   data = {{16{h[15]}}, h};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, b};
      F3_LHU:  data = {16'd0, h};
      default: data = 32'd0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: issues one word-aligned data-memory request
// per load/store, stalls the pipeline until acknowledge (or timeout), and
// hands extended load data to the MEM/WB register in the DONE cycle.
module lsu_mem_stage
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        insn_vldM,
  input  logic        mem_rdenM,
  input  logic        mem_wrenM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] alu_dataM,
  input  logic [31:0] st_dataM,
  output logic [31:0] ld_dataM,
  output logic        o_stallM,
  output logic        o_lsu_errM,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_ack,
  input  logic [31:0] i_dmem_rdata
);

  lsu_state_e  state_q, state_d;
  logic        req_q, we_q, err_q;
  logic [31:0] addr_q, wdata_q, ld_buf_q, cnt_q;
  logic [3:0]  be_q;
  logic [1:0]  off_q;
  logic [2:0]  f3_q;

  logic        access, is_store, legal;
  logic        accept, bad, ack_hit, expire;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ext_data;

  assign access   = insn_vldM & (mem_rdenM | mem_wrenM);
  assign is_store = mem_wrenM;
  assign legal    = lsu_access_ok(funct3M, alu_dataM[1:0], is_store);

  // Lane placement of the store data and its byte enables.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = st_dataM;
    case (funct3M)
      F3_LB, F3_LBU: begin
        be_d    = 4'b0001 << alu_dataM[1:0];
        wdata_d = {4{st_dataM[7:0]}};
      end
      F3_LH, F3_LHU: begin
        be_d    = 4'b0011 << alu_dataM[1:0];
        wdata_d = {2{st_dataM[15:0]}};
      end
      default: ;
    endcase
  end

  lsu_load_ext u_load_ext (
    .rdata  (i_dmem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ext_data)
  );

  // FSM state register.
  // NOTE: clocked state uses non-blocking (<=) so every register samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and stall decode; an ack on the expiry cycle takes priority.
  always_comb begin
    state_d  = state_q;
    o_stallM = 1'b0;
    accept   = 1'b0;
    bad      = 1'b0;
    ack_hit  = 1'b0;
    expire   = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (legal) begin
            accept   = 1'b1;
            o_stallM = 1'b1;
            state_d  = BUSY;
          end else begin
            bad = 1'b1;
          end
        end
      end
      BUSY: begin
        o_stallM = 1'b1;
        if (i_dmem_ack) begin
          ack_hit = 1'b1;
          state_d = DONE;
        end else if ((TIMEOUT_CYC != 0) && (cnt_q == 32'(TIMEOUT_CYC - 1))) begin
          expire  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request registers, timeout counter, load buffer and error pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      be_q     <= 4'd0;
      off_q    <= 2'd0;
      f3_q     <= 3'd0;
      cnt_q    <= 32'd0;
      ld_buf_q <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= bad | expire;
      if (accept) begin
        req_q   <= 1'b1;
        we_q    <= is_store;
        addr_q  <= {alu_dataM[31:2], 2'b00};
        wdata_q <= wdata_d;
        be_q    <= be_d;
        off_q   <= alu_dataM[1:0];
        f3_q    <= funct3M;
        cnt_q   <= 32'd0;
      end
      if (state_q == BUSY) cnt_q <= cnt_q + 32'd1;
      if (ack_hit || expire) begin
        req_q    <= 1'b0;
        we_q     <= 1'b0;
        addr_q   <= 32'd0;
        wdata_q  <= 32'd0;
        be_q     <= 4'd0;
        ld_buf_q <= (ack_hit && !we_q) ? ext_data : 32'd0;
      end
    end
  end

  assign o_dmem_req   = req_q;
  assign o_dmem_we    = we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_wdata = wdata_q;
  assign o_dmem_be    = be_q;
  assign o_lsu_errM   = err_q;
  assign ld_dataM     = (state_q == DONE) ? ld_buf_q : 32'd0;

endmodule
